// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Sequencing controller for the 4-stage 8-bit pipeline (IF, ID, EX, WB).
// It watches the instruction in the IF/ID register and tracks in-flight
// register writers in a two-slot scoreboard (EX, WB). From these it drives:
//   - PC, IF/ID and ID/EX enables and flushes
//   - the jump redirect
//   - EX operand-forward selects
//   - a saturating RAW stall counter
// All control outputs are combinational from registered state plus the ID
// inputs. o_state exposes the FSM state (0 = RUN, 1 = REDIRECT).
module pipeline_hazard_ctrl #(
    parameter int JUMP_BUBBLES = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_id_valid,
    input  logic [1:0] i_id_opcode,
    input  logic [2:0] i_id_rsrc,
    input  logic [2:0] i_id_rdest,
    input  logic [7:0] i_id_jump_address,
    output logic       o_pc_en,
    output logic       o_pc_load,
    output logic [7:0] o_pc_target,
    output logic       o_if_id_en,
    output logic       o_if_id_flush,
    output logic       o_id_ex_flush,
    output logic       o_fwd_rs,
    output logic       o_fwd_rd,
    output logic [7:0] o_stall_count,
    output logic       o_state
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_MOVI = 2'b01;
    localparam logic [1:0] OP_JUMP = 2'b10;

    localparam logic [2:0] BUBBLE_LOAD = 3'(JUMP_BUBBLES - 1);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;

    logic       r_ex_v;
    logic [2:0] r_ex_dest;
    logic       r_wb_v;
    logic [2:0] r_wb_dest;
    logic [7:0] r_stall_count;

    logic w_run;
    logic w_is_add;
    logic w_is_movi;
    logic w_is_jump;
    logic w_hazard;
    logic w_writer;
    logic w_jump;

    // ID decode.
    // Only RUN (and not reset) lets the ID instruction act; REDIRECT
    // treats ID as a NOP.
    assign w_run     = (r_state == ST_RUN) && !i_reset;
    assign w_is_add  = i_id_valid && (i_id_opcode == OP_ADD);
    assign w_is_movi = i_id_valid && (i_id_opcode == OP_MOVI);
    assign w_is_jump = i_id_valid && (i_id_opcode == OP_JUMP);

    // ADD reads both rs and rd.
    // A producer still in EX cannot be forwarded yet, so it forces a
    // one-cycle stall.
    assign w_hazard = w_run && w_is_add && r_ex_v &&
                      ((r_ex_dest == i_id_rsrc) || (r_ex_dest == i_id_rdest));
    assign w_writer = w_run && (w_is_add || w_is_movi) && !w_hazard;
    assign w_jump   = w_run && w_is_jump;

    // FSM state register: RUN / REDIRECT plus the bubble counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FSM next state.
    // A jump with more than one bubble parks in REDIRECT until the
    // counter reaches 1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_RUN: begin
                if (w_jump && (JUMP_BUBBLES > 1)) begin
                    w_state_nxt = ST_REDIRECT;
                    w_cnt_nxt   = BUBBLE_LOAD;
                end
            end
            ST_REDIRECT: begin
                w_cnt_nxt = r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // Scoreboard shift.
    // The WB slot inherits EX; EX records the current ID writer, if any.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ex_v    <= 1'b0;
            r_ex_dest <= 3'd0;
            r_wb_v    <= 1'b0;
            r_wb_dest <= 3'd0;
        end else begin
            r_wb_v    <= r_ex_v;
            r_wb_dest <= r_ex_dest;
            r_ex_v    <= w_writer;
            r_ex_dest <= w_writer ? i_id_rdest : 3'd0;
        end
    end

    // RAW stall counter; saturates at 255 with no wrap.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_count <= 8'd0;
        end else if (w_hazard && (r_stall_count != 8'hFF)) begin
            r_stall_count <= r_stall_count + 8'd1;
        end
    end

    // FSM outputs: pipeline enables, flushes, redirect and forward selects.
    always_comb begin
        o_pc_en       = 1'b0;
        o_pc_load     = 1'b0;
        o_pc_target   = 8'h00;
        o_if_id_en    = 1'b0;
        o_if_id_flush = 1'b0;
        o_id_ex_flush = 1'b0;
        o_fwd_rs      = 1'b0;
        o_fwd_rd      = 1'b0;
        if (i_reset) begin
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    o_pc_en    = 1'b1;
                    o_if_id_en = 1'b1;
                    if (w_hazard) begin
                        // Hold PC and IF/ID; push a bubble into EX.
                        o_pc_en       = 1'b0;
                        o_if_id_en    = 1'b0;
                        o_id_ex_flush = 1'b1;
                    end else if (w_is_add) begin
                        o_fwd_rs = r_wb_v && (r_wb_dest == i_id_rsrc);
                        o_fwd_rd = r_wb_v && (r_wb_dest == i_id_rdest);
                    end
                    if (w_jump) begin
                        // Redirect the PC.
                        // The wrong-path fetch is discarded; the JUMP itself
                        // proceeds into EX unchanged.
                        o_pc_load     = 1'b1;
                        o_pc_target   = i_id_jump_address;
                        o_if_id_flush = 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    o_pc_en       = 1'b1;
                    o_if_id_en    = 1'b1;
                    o_if_id_flush = 1'b1;
                end
                default: begin
                    o_if_id_flush = 1'b1;
                    o_id_ex_flush = 1'b1;
                end
            endcase
        end
    end

    assign o_stall_count = r_stall_count;
    assign o_state       = r_state;

endmodule
